fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the pipelined RISC CPU. It sits directly upstream of decode: it owns the PC, reads 16-bit instruction words, and loads the 5-bit opcode that feeds `control_unit` (bits [15:11] of `o_instr`). It also generates the `o_interrupt` flag that drives `control_unit.i_interrupt`. The stage loads the reset and interrupt vectors from instruction memory and handles stall, flush, branch redirect and interrupt injection.

---
 rtl/fetch_stage.sv | 154 +++++++++++++++
 tb/tb_fetch_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage and IF/ID register
// Owns the PC, loads reset/interrupt vectors from imem, injects interrupt packets.
module fetch_stage #(
  parameter int          PC_WIDTH       = 32,
  parameter int unsigned RESET_VEC_ADDR = 0,
  parameter int unsigned INT_VEC_ADDR   = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  output logic [PC_WIDTH-1:0] o_imem_addr,
  input  logic [15:0]         i_imem_data,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic                i_branch_taken,
  input  logic [PC_WIDTH-1:0] i_branch_target,
  input  logic                i_irq,
  output logic [15:0]         o_instr,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic                o_valid,
  output logic                o_interrupt
);

  typedef enum logic [2:0] {RST_LO, RST_HI, RUN, INT_LO, INT_HI} state_e;

  localparam logic [PC_WIDTH-1:0] RST_VEC = PC_WIDTH'(RESET_VEC_ADDR);
  localparam logic [PC_WIDTH-1:0] INT_VEC = PC_WIDTH'(INT_VEC_ADDR);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                pending_q, pending_d;
  logic [15:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] opc_q, opc_d;
  logic                valid_q, valid_d;
  logic                int_q, int_d;

  logic [PC_WIDTH-1:0] pc_inc, pc_lo_load, pc_hi_load;
  logic                in_int, redirect_int, inject;

  assign pc_inc       = pc_q + 1'b1;
  assign pc_lo_load   = PC_WIDTH'(i_imem_data);
  assign in_int       = (state_q == INT_LO) || (state_q == INT_HI);
  assign redirect_int = in_int && i_branch_taken;
  assign inject       = (state_q == RUN) && !i_branch_taken && !i_flush && !i_stall && pending_q;

  // The high vector word only lands in PC bits that exist, capped at bit 31.
  generate
    if (PC_WIDTH > 16) begin : g_hi
      localparam int HW = (PC_WIDTH >= 32) ? 16 : PC_WIDTH - 16;
      always_comb begin
        pc_hi_load          = pc_q;
        pc_hi_load[16 +: HW] = i_imem_data[HW-1:0];
      end
    end else begin : g_no_hi
      assign pc_hi_load = pc_q;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= RST_LO;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST_LO:  state_d = RST_HI;
      RST_HI:  state_d = RUN;
      RUN:     state_d = inject ? INT_LO : RUN;
      INT_LO:  state_d = redirect_int ? RUN : INT_HI;
      INT_HI:  state_d = RUN;
      default: state_d = RST_LO;
    endcase
  end

  always_comb begin
    case (state_q)
      RST_LO:  o_imem_addr = RST_VEC;
      RST_HI:  o_imem_addr = RST_VEC + 1'b1;
      INT_LO:  o_imem_addr = INT_VEC;
      INT_HI:  o_imem_addr = INT_VEC + 1'b1;
      default: o_imem_addr = pc_q;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    pending_d = pending_q;
    instr_d   = instr_q;
    opc_d     = opc_q;
    valid_d   = valid_q;
    int_d     = int_q;
    if (state_q != RUN) begin
      instr_d = 16'h0000;
      opc_d   = '0;
      valid_d = 1'b0;
      int_d   = 1'b0;
    end
    case (state_q)
      RST_LO: pc_d = pc_lo_load;
      RST_HI: pc_d = pc_hi_load;
      INT_LO: pc_d = i_branch_taken ? i_branch_target : pc_lo_load;
      INT_HI: pc_d = i_branch_taken ? i_branch_target : pc_hi_load;
      default: begin
        if (i_branch_taken || i_flush) begin
          pc_d    = i_branch_taken ? i_branch_target : pc_inc;
          instr_d = 16'h0000;
          opc_d   = '0;
          valid_d = 1'b0;
          int_d   = 1'b0;
        end else if (!i_stall) begin
          if (pending_q) begin
            instr_d   = 16'h0000;
            opc_d     = pc_q;
            valid_d   = 1'b1;
            int_d     = 1'b1;
            pending_d = 1'b0;
          end else begin
            instr_d = i_imem_data;
            opc_d   = pc_inc;
            valid_d = 1'b1;
            int_d   = 1'b0;
            pc_d    = pc_inc;
          end
        end
      end
    endcase
    // An aborted vector fetch retries the interrupt; a new pulse always wins over a clear.
    if (redirect_int || i_irq) pending_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_q      <= '0;
      pending_q <= 1'b0;
      instr_q   <= 16'h0000;
      opc_q     <= '0;
      valid_q   <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pending_q <= pending_d;
      instr_q   <= instr_d;
      opc_q     <= opc_d;
      valid_q   <= valid_d;
      int_q     <= int_d;
    end
  end

  assign o_instr     = instr_q;
  assign o_pc        = opc_q;
  assign o_valid     = valid_q;
  assign o_interrupt = int_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized bench for fetch_stage against a behavioural model
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall = 1'b0, flush = 1'b0, br = 1'b0, irq = 1'b0;
  logic [31:0] br_tgt = '0;
  logic [15:0] o_instr;
  logic [31:0] o_pc;
  logic        o_valid, o_interrupt;

  logic [15:0] mem [0:1023];
  assign imem_data = mem[imem_addr[9:0]];

  always #5 clk = ~clk;

  fetch_stage #(.PC_WIDTH(32), .RESET_VEC_ADDR(0), .INT_VEC_ADDR(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_addr(imem_addr), .i_imem_data(imem_data),
    .i_stall(stall), .i_flush(flush), .i_branch_taken(br), .i_branch_target(br_tgt),
    .i_irq(irq), .o_instr(o_instr), .o_pc(o_pc), .o_valid(o_valid), .o_interrupt(o_interrupt)
  );

  int total = 0;
  int bad   = 0;

  // model: m_vec 0 = fetching, 1 = loading reset vector, 2 = loading interrupt vector
  int          m_vec = 0, m_half = 0;
  bit          m_known = 0, m_pend = 0;
  logic [31:0] m_pc = '0;
  logic [15:0] e_instr = '0;
  logic [31:0] e_pc = '0;
  bit          e_valid = 0, e_int = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_addr();
    if (m_vec == 1) return 32'(m_half);
    if (m_vec == 2) return 32'(2 + m_half);
    return m_pc;
  endfunction

  function automatic void set_bubble();
    e_instr = 16'h0; e_pc = '0; e_valid = 0; e_int = 0;
  endfunction

  function automatic void model_edge(bit r, bit s, bit f, bit b, logic [31:0] t, bit q);
    logic [31:0] a;
    logic [15:0] d;
    if (!r) begin
      m_vec = 1; m_half = 0; m_pc = '0; m_pend = 0; m_known = 1;
      set_bubble();
      return;
    end
    a = exp_addr();
    d = mem[a[9:0]];
    if (m_vec != 0) begin
      set_bubble();
      if (m_vec == 2 && b) begin
        m_pc = t; m_pend = 1; m_vec = 0; m_half = 0;
      end else if (m_half == 0) begin
        m_pc = {16'h0, d}; m_half = 1;
      end else begin
        m_pc = {d, m_pc[15:0]}; m_vec = 0; m_half = 0;
      end
    end else if (b) begin
      m_pc = t; set_bubble();
    end else if (f) begin
      m_pc = m_pc + 1; set_bubble();
    end else if (s) begin
    end else if (m_pend) begin
      e_instr = 16'h0; e_pc = m_pc; e_valid = 1; e_int = 1;
      m_pend = 0; m_vec = 2; m_half = 0;
    end else begin
      e_instr = d; e_pc = m_pc + 1; e_valid = 1; e_int = 0;
      m_pc = m_pc + 1;
    end
    if (q) m_pend = 1;
  endfunction

  // Called at a negedge: drive, compare the current cycle, advance the model, cross one edge.
  task automatic step(input bit r, input bit s, input bit f, input bit b,
                      input logic [31:0] t, input bit q);
    rst_n = r; stall = s; flush = f; br = b; br_tgt = t; irq = q;
    #1;
    if (m_known) begin
      chk("addr",  imem_addr, exp_addr());
      chk("instr", 32'(o_instr), 32'(e_instr));
      chk("pc",    o_pc, e_pc);
      chk("valid", 32'(o_valid), 32'(e_valid));
      chk("intr",  32'(o_interrupt), 32'(e_int));
    end
    model_edge(r, s, f, b, t, q);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic nop();
    step(1, 0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0010; mem[1] = 16'h0000; mem[2] = 16'h0040; mem[3] = 16'h0000;
    mem[16] = 16'h5001; mem[20] = 16'h1234; mem[21] = 16'h2345; mem[50] = 16'h7777;
    @(negedge clk);

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_instr", 32'(o_instr), 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_int", 32'(o_interrupt), 0);
    chk("cyc0_addr", imem_addr, 0);
    nop(); chk("cyc1_addr", imem_addr, 1);
    nop(); chk("cyc2_addr", imem_addr, 16);
    nop();
    chk("cyc3_instr", 32'(o_instr), 32'h5001);
    chk("cyc3_pc", o_pc, 17);
    chk("cyc3_valid", 32'(o_valid), 1);

    step(1, 0, 0, 1, 20, 0);
    nop();
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("stall_addr", imem_addr, 21);
    chk("stall_instr", 32'(o_instr), 32'h1234);
    nop();
    chk("unstall_instr", 32'(o_instr), 32'h2345);
    chk("unstall_pc", o_pc, 22);
    step(1, 1, 1, 0, 0, 0);
    chk("flush_valid", 32'(o_valid), 0);
    chk("flush_addr", imem_addr, 23);

    step(1, 0, 0, 1, 30, 0);
    step(1, 0, 0, 1, 32'h100, 0);
    chk("br_valid", 32'(o_valid), 0);
    chk("br_instr", 32'(o_instr), 0);
    chk("br_addr", imem_addr, 32'h100);
    nop();
    chk("br_pc", o_pc, 32'h101);

    step(1, 0, 0, 1, 49, 0);
    step(1, 0, 0, 0, 0, 1);
    nop();
    chk("irq_int", 32'(o_interrupt), 1);
    chk("irq_pc", o_pc, 50);
    chk("irq_vlo", imem_addr, 2);
    nop(); chk("irq_vhi", imem_addr, 3);
    nop(); chk("isr_addr", imem_addr, 32'h40);
    step(1, 0, 0, 1, 50, 0);
    nop();
    chk("ret_instr", 32'(o_instr), 32'h7777);
    chk("ret_pc", o_pc, 51);

    step(1, 0, 0, 0, 0, 1);
    nop();
    chk("irqbr_intlo", imem_addr, 2);
    step(1, 0, 0, 1, 32'h80, 0);
    chk("irqbr_addr", imem_addr, 32'h80);
    chk("irqbr_valid", 32'(o_valid), 0);
    nop();
    chk("reinj_int", 32'(o_interrupt), 1);
    chk("reinj_pc", o_pc, 32'h80);
    nop(); nop();

    step(1, 0, 0, 1, 32'hFFFF_FFFF, 0);
    nop();
    chk("wrap_pc", o_pc, 0);
    chk("wrap_addr", imem_addr, 0);

    step(1, 0, 0, 0, 0, 1);
    nop(); nop();
    chk("inthi_addr", imem_addr, 3);
    step(0, 0, 0, 0, 0, 0);
    chk("midrst_valid", 32'(o_valid), 0);
    chk("midrst_addr", imem_addr, 0);
    nop(); nop(); nop();
    chk("drop_int", 32'(o_interrupt), 0);
    chk("drop_instr", 32'(o_instr), 32'h5001);

    for (int n = 0; n < 4000; n++) begin
      bit r, s, f, b, q;
      logic [31:0] t;
      r = ($urandom_range(0, 249) != 0);
      s = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 10) == 0);
      b = ($urandom_range(0, 8) == 0);
      q = ($urandom_range(0, 12) == 0);
      case ($urandom_range(0, 3))
        0:       t = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        1:       t = $urandom;
        default: t = 32'($urandom_range(0, 1023));
      endcase
      step(r, s, f, b, t, q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
